// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC types for the adder datapath and its accumulator.
// Provides DATA_WIDTH/data_t for the adder and ACC_WIDTH/acc_t/acc_state_t
// for the sum accumulator.
package soc_pkg;

  localparam int DATA_WIDTH = 8;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Eight bits of headroom: at least 128 full-scale samples before a wrap.
  localparam int ACC_WIDTH = DATA_WIDTH + 8;
  typedef logic [ACC_WIDTH-1:0] acc_t;

  typedef enum logic {ACC_ACCUM, ACC_HOLD} acc_state_t;

endpackage

// File: rtl/sum_accumulator_add_unit.sv
// acc_add_unit: combinational acc + zero-extended sample.
// Ports: acc (running total), sample ({carry, sum}), next_acc, ovf (carry out).
// With SUM_ACC_SATURATE_EN the result clamps to all-ones on carry; otherwise it wraps.
module acc_add_unit
  import soc_pkg::*;
#(
  parameter int ACC_WIDTH = soc_pkg::ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH:0]   sample,
  output logic [ACC_WIDTH-1:0]  next_acc,
  output logic                  ovf
);

  // One extra bit catches the carry out of the accumulator.
  logic [ACC_WIDTH:0] sum;

  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(sample);
  assign ovf = sum[ACC_WIDTH];

`ifdef SUM_ACC_SATURATE_EN
  // Once clamped, acc is all-ones, so any further non-zero sample carries
  // again and the total stays pinned for the rest of the window.
  assign next_acc = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign next_acc = sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums {in_carry, in_sum} samples over a window of NUM_SAMPLES
// (or fewer on flush) and holds the total/count/overflow until out_ready.
// Ports: clk, rst_n (sync, active-low), in_* valid/ready sample input, flush,
// out_* held result handshake. Optional macro: SUM_ACC_SATURATE_EN (saturate
// instead of wrap). Result visible 1 cycle after the closing accept/flush;
// in_ready is low while a result is held, giving one bubble per window.
module sum_accumulator
  import soc_pkg::*;
#(
  parameter  int NUM_SAMPLES = 4,
  parameter  int ACC_WIDTH   = soc_pkg::ACC_WIDTH,
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  data_t                in_sum,
  input  logic                 in_carry,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow
);

  acc_state_t           state, state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 accept;
  logic                 close;
  logic [DATA_WIDTH:0]  sample;
  logic [ACC_WIDTH-1:0] add_acc;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_upd;
  logic [CNT_W-1:0]     cnt_upd;
  logic                 ovf_upd;

  // Derived from state directly (not in_ready) to keep the comb paths acyclic.
  assign accept = in_valid && (state == ACC_ACCUM);

  // Gate the sample so X on an idle bus never reaches the adder.
  assign sample = accept ? {in_carry, in_sum} : '0;

  acc_add_unit #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .acc      (acc),
    .sample   (sample),
    .next_acc (add_acc),
    .ovf      (add_ovf)
  );

  // Post-update values for this cycle (unchanged when nothing is accepted).
  assign acc_upd = accept ? add_acc : acc;
  assign cnt_upd = accept ? cnt + CNT_W'(1) : cnt;
  assign ovf_upd = accept ? (ovf | add_ovf) : ovf;

  // A flush on an empty window with no accept produces nothing.
  assign close = (state == ACC_ACCUM) &&
                 ((accept && (cnt == CNT_W'(NUM_SAMPLES - 1))) ||
                  (flush && ((cnt != '0) || accept)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC_ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC_ACCUM: begin
        in_ready = 1'b1;
        if (close) state_nxt = ACC_HOLD;
      end
      ACC_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC_ACCUM;
      end
      default: state_nxt = ACC_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_acc      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (state == ACC_ACCUM) begin
      acc <= acc_upd;
      cnt <= cnt_upd;
      ovf <= ovf_upd;
      if (close) begin
        out_acc      <= acc_upd;
        out_count    <= cnt_upd;
        out_overflow <= ovf_upd;
      end
    end else if (out_ready) begin
      // Result consumed: start a fresh window. out_* keep their last value.
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;
  import soc_pkg::*;

  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_carry, flush, out_ready;
  data_t      in_sum;
  logic       in_ready, out_valid, out_overflow;
  logic [15:0] out_acc;
  logic [CNT_W-1:0] out_count;

  logic       v9, c9, rdy9;
  data_t      s9;
  logic       ir9, ov9, of9;
  logic [8:0] acc9;
  logic [CNT_W-1:0] cnt9;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.NUM_SAMPLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  sum_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(v9), .in_ready(ir9),
    .in_sum(s9), .in_carry(c9), .flush(1'b0),
    .out_valid(ov9), .out_ready(rdy9), .out_acc(acc9),
    .out_count(cnt9), .out_overflow(of9)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle, then idle the bus with X.
  task automatic send(input logic [8:0] val);
    in_valid = 1'b1;
    {in_carry, in_sum} = val;
    tick();
    in_valid = 1'b0;
    in_carry = 1'bx;
    in_sum   = 'x;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_acc"},   out_acc, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_ovf"},   out_overflow, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_carry = 1'b0; in_sum = '0;
    flush = 1'b0; out_ready = 1'b1;
    v9 = 1'b0; c9 = 1'b0; s9 = '0; rdy9 = 1'b1;
    tick(); tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Full window, back to back: 0xFF + 0x101 + 0x10 + 0x20 = 0x230.
    in_valid = 1'b1;
    {in_carry, in_sum} = 9'h0FF; tick();
    check("w1_not_yet", out_valid, 0);
    {in_carry, in_sum} = 9'h101; tick();
    {in_carry, in_sum} = 9'h010; tick();
    {in_carry, in_sum} = 9'h020; tick();
    in_valid = 1'b0;
    check("w1_valid", out_valid, 1);
    check("w1_acc",   out_acc, 16'h230);
    check("w1_count", out_count, 4);
    check("w1_ovf",   out_overflow, 0);
    check("w1_in_rdy", in_ready, 0);
    tick();
    check("w1_drained", out_valid, 0);

    // Early close by flush alone.
    send(9'h005);
    send(9'h007);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_valid", out_valid, 1);
    check("fl_acc",   out_acc, 16'h00C);
    check("fl_count", out_count, 2);
    tick();
    check("fl_drained", out_valid, 0);

    // Flush on an empty window is ignored.
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_empty_valid", out_valid, 0);
    check("fl_empty_rdy",   in_ready, 1);
    tick();
    check("fl_empty_valid2", out_valid, 0);

    // Flush together with the third accept includes that sample.
    send(9'h001);
    send(9'h002);
    flush = 1'b1; send(9'h003); flush = 1'b0;
    check("flacc_valid", out_valid, 1);
    check("flacc_acc",   out_acc, 16'h006);
    check("flacc_count", out_count, 3);
    tick();
    check("flacc_drained", out_valid, 0);

    // Hold the result under backpressure while the source keeps offering.
    out_ready = 1'b0;
    send(9'h001); send(9'h002); send(9'h003); send(9'h004);
    in_valid = 1'b1;
    {in_carry, in_sum} = 9'h055;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_in_rdy", i), in_ready, 0);
      check($sformatf("hold%0d_valid", i),  out_valid, 1);
      check($sformatf("hold%0d_acc", i),    out_acc, 16'h00A);
      check($sformatf("hold%0d_count", i),  out_count, 4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bubble_valid", out_valid, 0);
    check("bubble_in_rdy", in_ready, 1);
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    check("resume_valid", out_valid, 1);
    check("resume_acc",   out_acc, 16'h154);
    check("resume_count", out_count, 4);
    tick();

    // Reset mid-window discards the partial sum.
    send(9'h001);
    send(9'h002);
    rst_n = 1'b0; tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    send(9'h001); send(9'h001); send(9'h001);
    check("midrst_no_early", out_valid, 0);
    send(9'h001);
    check("midrst_valid", out_valid, 1);
    check("midrst_acc",   out_acc, 16'h004);
    check("midrst_count", out_count, 4);
    tick();

    // Narrow accumulator: 4 x 0x1FF = 0x7FC exceeds 9 bits.
    v9 = 1'b1; {c9, s9} = 9'h1FF;
    tick(); tick(); tick(); tick();
    v9 = 1'b0;
    check("ovf_valid", ov9, 1);
    check("ovf_count", cnt9, 4);
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_acc", acc9, 9'h1FF);
`else
    check("ovf_acc", acc9, 9'h1FC);
`endif
    check("ovf_flag", of9, 1);
    tick();
    check("ovf_drained", ov9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
